// File: rtl/pj_defs.sv
// Shared project definitions: sequencer state codes, dwell defaults and timer width.
package pj_defs;

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        CARREGA = 3'd1,
        MOSTRA  = 3'd2,
        APAGA   = 3'd3,
        FIM     = 3'd4
    } estado_t;

    localparam int unsigned T_ON_PADRAO  = 1000;
    localparam int unsigned T_OFF_PADRAO = 500;
    localparam int          TMR_W        = 16;

endpackage

// File: rtl/temporizador.sv
// 16-bit dwell timer: counts enabled cycles from zero, fim flags the last cycle of a tc-cycle dwell.
module temporizador
    import pj_defs::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMR_W-1:0] tc,
    output logic             fim
);

    logic [TMR_W-1:0] contagem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (enable) begin
            contagem <= contagem + 1'b1;
        end
    end

    // tc is at least 1, so the count peaks at 65534 and never wraps
    assign fim = enable && (contagem == tc - 1'b1);

endmodule

// File: rtl/exibidor_sequencia.sv
// Steps through ROM addresses 0..limite, showing each value for T_ON cycles then blanking for T_OFF.
//
// state   | meaning
// INICIAL | idle, waiting for iniciar
// CARREGA | one cycle, ROM data for the current address is latched
// MOSTRA  | latched value on leds for T_ON cycles
// APAGA   | leds blanked for T_OFF cycles, then next address or FIM
// FIM     | one-cycle pronto pulse
module exibidor_sequencia
    import pj_defs::*;
#(
    parameter int unsigned T_ON  = T_ON_PADRAO,
    parameter int unsigned T_OFF = T_OFF_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    output logic [3:0] mem_endereco,
    input  logic [3:0] mem_dado,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       pronto,
    output logic [2:0] db_estado
);

    localparam logic [TMR_W-1:0] TC_ON  = TMR_W'(T_ON);
    localparam logic [TMR_W-1:0] TC_OFF = TMR_W'(T_OFF);

    estado_t          estado;
    logic [3:0]       endereco;
    logic [3:0]       limite_q;
    logic [3:0]       valor;
    logic             tmr_fim;
    logic             tmr_enable;
    logic             tmr_clear;
    logic [TMR_W-1:0] tmr_tc;
    logic             avanca;

    assign tmr_enable = (estado == MOSTRA) || (estado == APAGA);
    assign tmr_clear  = !tmr_enable || tmr_fim;
    assign tmr_tc     = (estado == MOSTRA) ? TC_ON : TC_OFF;

    temporizador u_temporizador (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .tc     (tmr_tc),
        .fim    (tmr_fim)
    );

    // The synchronous ROM needs the next address one edge before CARREGA closes,
    // so the increment is presented during the last APAGA cycle.
    assign avanca       = (estado == APAGA) && tmr_fim && (endereco != limite_q);
    assign mem_endereco = avanca ? endereco + 4'd1 : endereco;
    assign db_estado    = estado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            endereco <= '0;
            limite_q <= '0;
            valor    <= '0;
            leds     <= '0;
            exibindo <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            case (estado)
                INICIAL: begin
                    leds     <= '0;
                    pronto   <= 1'b0;
                    endereco <= '0;
                    if (iniciar) begin
                        limite_q <= limite;
                        exibindo <= 1'b1;
                        estado   <= CARREGA;
                    end else begin
                        exibindo <= 1'b0;
                    end
                end
                CARREGA: begin
                    valor  <= mem_dado;
                    leds   <= mem_dado;
                    estado <= MOSTRA;
                end
                MOSTRA: begin
                    if (tmr_fim) begin
                        leds   <= '0;
                        estado <= APAGA;
                    end else begin
                        leds <= valor;
                    end
                end
                APAGA: begin
                    leds <= '0;
                    if (tmr_fim) begin
                        if (endereco == limite_q) begin
                            pronto <= 1'b1;
                            estado <= FIM;
                        end else begin
                            endereco <= mem_endereco;
                            estado   <= CARREGA;
                        end
                    end
                end
                FIM: begin
                    leds     <= '0;
                    pronto   <= 1'b0;
                    exibindo <= 1'b0;
                    endereco <= '0;
                    estado   <= INICIAL;
                end
                default: begin
                    leds     <= '0;
                    pronto   <= 1'b0;
                    exibindo <= 1'b0;
                    endereco <= '0;
                    estado   <= INICIAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Directed bench for exibidor_sequencia with T_ON=3, T_OFF=2 and a synchronous 16x4 ROM model.
module tb_exibidor_sequencia;

    localparam int PER = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] limite = 4'd0;
    logic [3:0] mem_endereco;
    logic [3:0] mem_dado;
    logic [3:0] leds;
    logic       exibindo;
    logic       pronto;
    logic [2:0] db_estado;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int lim;
        bit hold;
        bit disturb;
        int pk;
    } vec_t;

    vec_t tab[6];

    exibidor_sequencia #(.T_ON(3), .T_OFF(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .limite       (limite),
        .mem_endereco (mem_endereco),
        .mem_dado     (mem_dado),
        .leds         (leds),
        .exibindo     (exibindo),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] rom_val(input logic [3:0] a);
        case (a)
            4'd0:    return 4'h5;
            4'd1:    return 4'hA;
            4'd2:    return 4'h3;
            4'd3:    return 4'hF;
            default: return a;
        endcase
    endfunction

    always_ff @(posedge clock) mem_dado <= rom_val(mem_endereco);

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s k=%0d got=%0h exp=%0h", nm, k, act, exp);
    endtask

    // expected outputs kk cycles after the sampling edge of iniciar
    task automatic check_cycle(input int kk, input int lim, input int k);
        int ni;
        int i;
        int p;
        int est;
        int ld;
        ni = PER * (lim + 1);
        if (kk < ni) begin
            i   = kk / PER;
            p   = kk % PER;
            est = (p == 0) ? 1 : (p <= 3) ? 2 : 3;
            ld  = (p >= 1 && p <= 3) ? int'(rom_val(4'(i))) : 0;
            chk("estado", k, 32'(db_estado), 32'(est));
            chk("leds", k, 32'(leds), 32'(ld));
            chk("exibindo", k, 32'(exibindo), 32'd1);
            chk("pronto", k, 32'(pronto), 32'd0);
            if (p <= 4) chk("endereco", k, 32'(mem_endereco), 32'(i));
        end else if (kk == ni) begin
            chk("estado", k, 32'(db_estado), 32'd4);
            chk("leds", k, 32'(leds), 32'd0);
            chk("exibindo", k, 32'(exibindo), 32'd1);
            chk("pronto", k, 32'(pronto), 32'd1);
        end else begin
            chk("estado", k, 32'(db_estado), 32'd0);
            chk("leds", k, 32'(leds), 32'd0);
            chk("exibindo", k, 32'(exibindo), 32'd0);
            chk("pronto", k, 32'(pronto), 32'd0);
            chk("endereco", k, 32'(mem_endereco), 32'd0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int p_len;
        int n;
        int pk;
        p_len = PER * (v.lim + 1) + 2;
        n     = v.hold ? 2 * p_len : p_len;
        pk    = -1;
        @(negedge clock);
        limite  = 4'(v.lim);
        iniciar = 1'b1;
        @(posedge clock);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (!v.hold || k == p_len) iniciar = 1'b0;
            if (v.disturb && k == 13) begin
                iniciar = 1'b1;
                limite  = 4'd1;
            end
            check_cycle(k % p_len, v.lim, k);
            if (pronto === 1'b1 && pk < 0) pk = k;
        end
        iniciar = 1'b0;
        chk("ciclo_pronto", v.lim, 32'(pk), 32'(v.pk));
    endtask

    initial begin
        tab[0] = '{lim: 3,  hold: 1'b0, disturb: 1'b0, pk: 24};
        tab[1] = '{lim: 0,  hold: 1'b0, disturb: 1'b0, pk: 6};
        tab[2] = '{lim: 15, hold: 1'b0, disturb: 1'b0, pk: 96};
        tab[3] = '{lim: 3,  hold: 1'b0, disturb: 1'b1, pk: 24};
        tab[4] = '{lim: 0,  hold: 1'b1, disturb: 1'b0, pk: 6};
        tab[5] = '{lim: 2,  hold: 1'b0, disturb: 1'b0, pk: 18};

        repeat (3) @(negedge clock);
        chk("rst_leds", 0, 32'(leds), 32'd0);
        chk("rst_exibindo", 0, 32'(exibindo), 32'd0);
        chk("rst_pronto", 0, 32'(pronto), 32'd0);
        chk("rst_estado", 0, 32'(db_estado), 32'd0);
        chk("rst_endereco", 0, 32'(mem_endereco), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int t = 0; t < 6; t++) run_vec(tab[t]);

        // abort during APAGA of item 1 with an asynchronous reset
        repeat (2) @(negedge clock);
        limite  = 4'd3;
        iniciar = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clock);
            iniciar = 1'b0;
        end
        chk("pre_rst_estado", 10, 32'(db_estado), 32'd3);
        chk("pre_rst_exibindo", 10, 32'(exibindo), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_leds", 10, 32'(leds), 32'd0);
        chk("arst_exibindo", 10, 32'(exibindo), 32'd0);
        chk("arst_estado", 10, 32'(db_estado), 32'd0);
        chk("arst_pronto", 10, 32'(pronto), 32'd0);
        chk("arst_endereco", 10, 32'(mem_endereco), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clock);
                if (pronto !== 1'b0 || db_estado !== 3'd0) seen++;
            end
            chk("pos_rst_ocioso", 40, 32'(seen), 32'd0);
        end

        run_vec(tab[1]);
        run_vec(tab[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
